io_request_arbiter: RTL and testbench

IO_REQUEST_ARBITER -- requirements
Module: io_request_arbiter

---
 rtl/io_request_arbiter_pkg.sv | 21 ++
 rtl/io_request_arbiter_rr_pick4.sv | 19 +
 rtl/io_request_arbiter.sv | 123 ++++++++++++
 tb/tb_io_request_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_request_arbiter_pkg.sv
// Shared encodings and lane geometry for the processor IO request arbiter.
package io_request_arbiter_pkg;
  localparam int LANE_W  = 32;
  localparam int NUM_DEV = 4;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_HOLD = 2'd1,
    I_ACK  = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE   = 2'd0,
    O_DRIVE  = 2'd1,
    O_FINISH = 2'd2
  } out_state_t;

  function automatic logic [NUM_DEV-1:0] dev_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/io_request_arbiter_rr_pick4.sv
// Round-robin pick of four requesters, searching upward from ptr with wrap.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       valid
);
  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = ptr;
    valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        grant = ptr + 2'(k);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/io_request_arbiter.sv
// Arbitrates device input words to the processor and drives processor output
// words to one device with a bounded wait for the device's done.
//   state    | meaning
//   I_IDLE   | waiting for in_ready with at least one enter_in request
//   I_HOLD   | granted word presented until the processor drops in_ready
//   I_ACK    | enter_ack pulse to the granted device, pointer advanced
//   O_IDLE   | waiting for out_req
//   O_DRIVE  | word on the target lane, waiting for done_out or timeout
//   O_FINISH | lanes released, out_done pulse
module io_request_arbiter
  import io_request_arbiter_pkg::*;
#(
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DEV*LANE_W-1:0]   dev_in,
  input  logic [NUM_DEV-1:0]          enter_in,
  output logic [NUM_DEV-1:0]          enter_ack,
  input  logic                        in_ready,
  output logic                        in_valid,
  output logic [LANE_W-1:0]           in_data,
  output logic [1:0]                  in_dev,
  input  logic                        out_req,
  input  logic [LANE_W-1:0]           out_word,
  input  logic [1:0]                  out_sel,
  output logic [NUM_DEV*LANE_W-1:0]   dev_out,
  output logic [NUM_DEV-1:0]          enter_out,
  input  logic [NUM_DEV-1:0]          done_out,
  output logic                        out_done,
  output logic                        out_timeout
);
  localparam int TMR_W = (DONE_TIMEOUT < 1) ? 1 : $clog2(DONE_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(DONE_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DONE_TIMEOUT - 1);

  in_state_t        in_state;
  out_state_t       out_state;
  logic [1:0]       rr_ptr;
  logic [1:0]       pick_idx;
  logic             pick_valid;
  logic [1:0]       sel_q;
  logic [TMR_W-1:0] timer;

  rr_pick4 u_rr_pick4 (
    .req   (enter_in),
    .ptr   (rr_ptr),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state  <= I_IDLE;
      rr_ptr    <= '0;
      in_valid  <= 1'b0;
      in_data   <= '0;
      in_dev    <= '0;
      enter_ack <= '0;
    end else begin
      enter_ack <= '0;
      case (in_state)
        I_IDLE: begin
          if (in_ready && pick_valid) begin
            in_data  <= dev_in[pick_idx*LANE_W +: LANE_W];
            in_dev   <= pick_idx;
            in_valid <= 1'b1;
            in_state <= I_HOLD;
          end
        end
        I_HOLD: begin
          if (!in_ready) begin
            in_valid  <= 1'b0;
            enter_ack <= dev_onehot(in_dev);
            rr_ptr    <= in_dev + 2'd1;
            in_state  <= I_ACK;
          end
        end
        I_ACK:   in_state <= I_IDLE;
        default: in_state <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state   <= O_IDLE;
      sel_q       <= '0;
      timer       <= '0;
      dev_out     <= '0;
      enter_out   <= '0;
      out_done    <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (out_state)
        O_IDLE: begin
          if (out_req) begin
            sel_q       <= out_sel;
            timer       <= '0;
            out_timeout <= 1'b0;
            enter_out   <= dev_onehot(out_sel);
            dev_out     <= {{(NUM_DEV-1)*LANE_W{1'b0}}, out_word} << (out_sel*LANE_W);
            out_state   <= O_DRIVE;
          end
        end
        O_DRIVE: begin
          // done is tested first so a same-cycle done is not reported as a timeout
          if (done_out[sel_q] || timer == TMR_LAST) begin
            out_timeout <= !done_out[sel_q];
            enter_out   <= '0;
            dev_out     <= '0;
            out_done    <= 1'b1;
            out_state   <= O_FINISH;
          end
          if (timer != TMR_MAX) timer <= timer + TMR_W'(1);
        end
        O_FINISH: out_state <= O_IDLE;
        default:  out_state <= O_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_request_arbiter.sv
// Directed bench for io_request_arbiter with a scoreboard of expected grants,
// acks and output completions.
module tb_io_request_arbiter;
  localparam int TO = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] dev_in;
  logic [3:0]   enter_in;
  logic [3:0]   enter_ack;
  logic         in_ready;
  logic         in_valid;
  logic [31:0]  in_data;
  logic [1:0]   in_dev;
  logic         out_req;
  logic [31:0]  out_word;
  logic [1:0]   out_sel;
  logic [127:0] dev_out;
  logic [3:0]   enter_out;
  logic [3:0]   done_out;
  logic         out_done;
  logic         out_timeout;

  typedef struct {
    logic [1:0]  dev;
    logic [31:0] data;
  } in_exp_t;

  in_exp_t    exp_in[$];
  logic [3:0] exp_ack[$];
  logic       exp_to[$];
  int         n_checks = 0;
  int         n_err = 0;
  logic       in_valid_q = 1'b0;

  always #5 clk = ~clk;

  io_request_arbiter #(.DONE_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dev_in      (dev_in),
    .enter_in    (enter_in),
    .enter_ack   (enter_ack),
    .in_ready    (in_ready),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_dev      (in_dev),
    .out_req     (out_req),
    .out_word    (out_word),
    .out_sel     (out_sel),
    .dev_out     (dev_out),
    .enter_out   (enter_out),
    .done_out    (done_out),
    .out_done    (out_done),
    .out_timeout (out_timeout)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every grant, ack and completion must match the oldest expectation.
  always @(negedge clk) begin
    in_exp_t e;
    logic [3:0] a;
    logic t;
    if (in_valid && !in_valid_q) begin
      if (exp_in.size() == 0) chk("unexpected_grant", 1, 0);
      else begin
        e = exp_in.pop_front();
        chk("in_dev", in_dev, e.dev);
        chk("in_data", in_data, e.data);
      end
    end
    in_valid_q = in_valid;
    if (enter_ack != 4'b0) begin
      if (exp_ack.size() == 0) chk("unexpected_ack", enter_ack, 0);
      else begin
        a = exp_ack.pop_front();
        chk("enter_ack", enter_ack, a);
      end
    end
    if (out_done) begin
      if (exp_to.size() == 0) chk("unexpected_out_done", 1, 0);
      else begin
        t = exp_to.pop_front();
        chk("out_timeout", out_timeout, t);
        chk("finish_enter_out", enter_out, 0);
        chk("finish_dev_out", dev_out, 0);
      end
    end
  end

  task automatic in_txn(input logic [3:0] req, input logic [1:0] exp_dev);
    in_exp_t e;
    int n;
    @(negedge clk);
    enter_in = req;
    in_ready = 1'b1;
    e.dev = exp_dev;
    e.data = dev_in[exp_dev*32 +: 32];
    exp_in.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!in_valid && n < 10);
    chk("grant_latency", n, 1);
    enter_in = 4'b0;
    dev_in = ~dev_in;
    @(negedge clk);
    chk("hold_valid", in_valid, 1);
    chk("hold_data", in_data, e.data);
    in_ready = 1'b0;
    exp_ack.push_back(4'b0001 << exp_dev);
    n = 0;
    do begin @(negedge clk); n++; end while (enter_ack == 4'b0 && n < 10);
    chk("ack_latency", n, 1);
    chk("ack_valid_low", in_valid, 0);
    @(negedge clk);
    chk("ack_width", enter_ack, 0);
  endtask

  // done_at: drive cycle in which done_out[sel] rises, 0 for never.
  task automatic out_txn(input logic [1:0] sel, input logic [31:0] word, input int done_at,
                         input logic to_exp);
    logic [127:0] lane;
    int n;
    lane = {96'd0, word} << (sel*32);
    @(negedge clk);
    out_sel = sel;
    out_word = word;
    out_req = 1'b1;
    exp_to.push_back(to_exp);
    @(negedge clk);
    out_req = 1'b0;
    n = 0;
    while (!out_done && n < TO + 5) begin
      n++;
      chk("drive_enter_out", enter_out, 4'b0001 << sel);
      chk("drive_dev_out", dev_out, lane);
      chk("drive_timeout_clear", out_timeout, 0);
      done_out = (n == done_at) ? (4'b0001 << sel) : ~(4'b0001 << sel);
      out_req = (n == 2);
      out_sel = sel ^ 2'd1;
      out_word = ~word;
      @(negedge clk);
    end
    done_out = 4'b0;
    out_req = 1'b0;
    chk("drive_cycles", n, (done_at != 0) ? done_at : TO);
    @(negedge clk);
    chk("out_done_width", out_done, 0);
    chk("out_timeout_sticky", out_timeout, to_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_exp_t e;
    rst_n = 1'b0;
    dev_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    enter_in = 4'b0;
    in_ready = 1'b0;
    out_req = 1'b0;
    out_word = 32'h0;
    out_sel = 2'd0;
    done_out = 4'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_in_data", in_data, 0);
    chk("rst_in_dev", in_dev, 0);
    chk("rst_enter_ack", enter_ack, 0);
    chk("rst_dev_out", dev_out, 0);
    chk("rst_enter_out", enter_out, 0);
    chk("rst_out_done", out_done, 0);
    chk("rst_out_timeout", out_timeout, 0);
    rst_n = 1'b1;

    dev_in = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    in_txn(4'b1010, 2'd1);
    in_txn(4'b1010, 2'd3);
    in_txn(4'b1010, 2'd1);

    @(negedge clk);
    enter_in = 4'b1111;
    in_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_grant_unready", in_valid, 0);
    end
    enter_in = 4'b0;

    out_txn(2'd2, 32'hDEAD_BEEF, 5, 1'b0);
    out_txn(2'd1, 32'h1234_5678, 0, 1'b1);
    out_txn(2'd3, 32'h0BAD_F00D, 1, 1'b0);
    out_txn(2'd0, 32'h5A5A_A5A5, TO, 1'b0);

    // rr_ptr is 2 here: grant device 2 while an output to device 1 runs.
    @(negedge clk);
    enter_in = 4'b0100;
    in_ready = 1'b1;
    e.dev = 2'd2;
    e.data = dev_in[95:64];
    exp_in.push_back(e);
    out_sel = 2'd1;
    out_word = 32'hCAFE_F00D;
    out_req = 1'b1;
    exp_to.push_back(1'b0);
    @(negedge clk);
    out_req = 1'b0;
    chk("sim_in_valid", in_valid, 1);
    chk("sim_enter_out", enter_out, 4'b0010);
    in_ready = 1'b0;
    enter_in = 4'b0;
    done_out = 4'b0010;
    exp_ack.push_back(4'b0100);
    @(negedge clk);
    chk("sim_enter_ack", enter_ack, 4'b0100);
    chk("sim_out_done", out_done, 1);
    done_out = 4'b0;

    // rr_ptr is 3: device 0 wins, then reset mid-transaction on both paths.
    @(negedge clk);
    out_sel = 2'd2;
    out_word = 32'h7777_8888;
    out_req = 1'b1;
    enter_in = 4'b0001;
    in_ready = 1'b1;
    e.dev = 2'd0;
    e.data = dev_in[31:0];
    exp_in.push_back(e);
    @(negedge clk);
    out_req = 1'b0;
    enter_in = 4'b0;
    chk("pre_rst_enter_out", enter_out, 4'b0100);
    chk("pre_rst_in_valid", in_valid, 1);
    #2;
    rst_n = 1'b0;
    done_out = 4'b0100;
    in_ready = 1'b0;
    #1;
    chk("arst_in_valid", in_valid, 0);
    chk("arst_in_data", in_data, 0);
    chk("arst_in_dev", in_dev, 0);
    chk("arst_enter_out", enter_out, 0);
    chk("arst_dev_out", dev_out, 0);
    chk("arst_out_done", out_done, 0);
    chk("arst_enter_ack", enter_ack, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_out = 4'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_out_done", out_done, 0);

    in_txn(4'b1111, 2'd0);

    repeat (3) @(negedge clk);
    chk("left_grants", exp_in.size(), 0);
    chk("left_acks", exp_ack.size(), 0);
    chk("left_out_done", exp_to.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
